// File: rtl/addition_normalize_pkg.sv
// Shared definitions for the single-precision adder datapath stages.
// Holds the default field widths, the all-ones exponent and the
// normalizer FSM state encoding so every stage agrees on them.
package addition_normalize_pkg;

    localparam int FPU_MENT_WIDTH = 23;   // fraction width, hidden bit excluded
    localparam int FPU_EXPO_WIDTH = 8;    // biased exponent width
    localparam logic [FPU_EXPO_WIDTH-1:0] FPU_EXPO_MAX = '1;  // Inf/NaN exponent

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } norm_state_t;

endpackage

// File: rtl/addition_normalize_if.sv
// Handshake bundle between the mantissa adder, the normalizer and the
// downstream rounding stage. slave = normalizer side, master = the side
// that supplies operands and consumes results.
interface addition_normalize_if #(
    parameter int MENT_WIDTH = addition_normalize_pkg::FPU_MENT_WIDTH,
    parameter int EXPO_WIDTH = addition_normalize_pkg::FPU_EXPO_WIDTH
);
    // operand side
    logic                   in_valid;
    logic                   in_ready;
    logic [MENT_WIDTH+1:0]  sum_ment_in;   // {carry, hidden, fraction}
    logic [EXPO_WIDTH-1:0]  expo_in;
    logic                   sign_in;
    // result side
    logic                   out_valid;
    logic                   out_ready;
    logic [MENT_WIDTH-1:0]  ment_out;
    logic [EXPO_WIDTH-1:0]  expo_out;
    logic                   sign_out;
    logic                   overflow_out;
    logic                   underflow_out;
    logic                   zero_out;

    modport slave (
        input  in_valid, sum_ment_in, expo_in, sign_in, out_ready,
        output in_ready, out_valid, ment_out, expo_out, sign_out,
               overflow_out, underflow_out, zero_out
    );

    modport master (
        output in_valid, sum_ment_in, expo_in, sign_in, out_ready,
        input  in_ready, out_valid, ment_out, expo_out, sign_out,
               overflow_out, underflow_out, zero_out
    );

endinterface

// File: rtl/addition_normalize.sv
// Purpose: renormalize the raw adder sum (one right shift on carry, or one left shift per cycle), adjust and saturate the exponent.
// Latency: 2 + k cycles from accept to out_valid (k = left shifts), +1 when the underflow clamp fires; max MENT_WIDTH+2.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready; one idle cycle between operations.
//
// Ports: clk, rst_n (synchronous, active low), bus (slave modport) carrying
// in_valid/in_ready/sum_ment_in/expo_in/sign_in and
// out_valid/out_ready/ment_out/expo_out/sign_out/overflow_out/underflow_out/zero_out.
module addition_normalize
    import addition_normalize_pkg::*;
#(
    parameter int MENT_WIDTH = FPU_MENT_WIDTH,
    parameter int EXPO_WIDTH = FPU_EXPO_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    addition_normalize_if.slave bus
);

    localparam int MW = MENT_WIDTH + 2;
    localparam logic [EXPO_WIDTH-1:0] EXPO_ALL1 = '1;
    // A carry at this exponent or above would land on the Inf/NaN code.
    localparam logic [EXPO_WIDTH-1:0] EXPO_OVF  = EXPO_ALL1 - 1'b1;
    localparam logic [EXPO_WIDTH-1:0] EXPO_ONE  = EXPO_WIDTH'(1);

    norm_state_t            state;
    logic [MW-1:0]          ment_r;
    logic [EXPO_WIDTH-1:0]  expo_r;
    logic                   sign_r;
    logic                   ovf_r;
    logic                   udf_r;
    logic                   zero_r;
    logic                   in_ready_r;
    logic                   out_valid_r;

    logic carry_bit;
    logic hidden_bit;
    logic below_hidden;

    assign carry_bit    = ment_r[MW-1];
    assign hidden_bit   = ment_r[MENT_WIDTH];
    // When this bit is set the current left shift is the last one needed.
    assign below_hidden = ment_r[MENT_WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ment_r      <= '0;
            expo_r      <= '0;
            sign_r      <= 1'b0;
            ovf_r       <= 1'b0;
            udf_r       <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        ment_r     <= bus.sum_ment_in;
                        expo_r     <= bus.expo_in;
                        sign_r     <= bus.sign_in;
                        ovf_r      <= 1'b0;
                        udf_r      <= 1'b0;
                        zero_r     <= 1'b0;
                        in_ready_r <= 1'b0;
                        state      <= ST_EVAL;
                    end
                end

                ST_EVAL: begin
                    if (ment_r == '0) begin
                        expo_r      <= '0;
                        zero_r      <= 1'b1;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else if (carry_bit && (expo_r >= EXPO_OVF)) begin
                        // Saturate to infinity: max exponent, empty fraction.
                        expo_r                 <= EXPO_ALL1;
                        ment_r[MENT_WIDTH-1:0] <= '0;
                        ovf_r                  <= 1'b1;
                        out_valid_r            <= 1'b1;
                        state                  <= ST_DONE;
                    end else if (carry_bit) begin
                        ment_r      <= ment_r >> 1;
                        expo_r      <= expo_r + 1'b1;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else if (hidden_bit) begin
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (expo_r <= EXPO_ONE) begin
                        // No exponent left to trade: stop as a denormal.
                        expo_r      <= '0;
                        udf_r       <= 1'b1;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        ment_r <= ment_r << 1;
                        expo_r <= expo_r - 1'b1;
                        if (below_hidden) begin
                            out_valid_r <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.ment_out      = ment_r[MENT_WIDTH-1:0];
    assign bus.expo_out      = expo_r;
    assign bus.sign_out      = sign_r;
    assign bus.overflow_out  = ovf_r;
    assign bus.underflow_out = udf_r;
    assign bus.zero_out      = zero_r;

endmodule

// File: tb/tb_addition_normalize.sv
// Bench for addition_normalize: directed cases, randomized operands against
// an arithmetic reference model, backpressure, back-to-back and mid-op reset.
module tb_addition_normalize;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    addition_normalize_if bus_if ();

    addition_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ment, expo, sign, overflow, underflow, zero}
    function automatic logic [34:0] dut_res();
        return {bus_if.ment_out, bus_if.expo_out, bus_if.sign_out,
                bus_if.overflow_out, bus_if.underflow_out, bus_if.zero_out};
    endfunction

    // Reference: decide the outcome from the value of the sum, then compute
    // the normalizing shift distance directly from the leading-one position.
    task automatic ref_model(input logic [24:0] s, input logic [7:0] e, input logic sg,
                             output logic [34:0] res, output int lat);
        logic [31:0] s32;
        logic [31:0] sh;
        logic [22:0] m;
        logic [7:0]  eo;
        logic        ov, uf, zr;
        int          p, n, k;
        s32 = 32'(s);
        m = '0; eo = e; ov = 0; uf = 0; zr = 0; lat = 2;
        if (s == 0) begin
            eo = 8'h00; zr = 1;
        end else if (s >= 25'h1000000) begin
            if (int'(e) >= 254) begin
                eo = 8'hFF; ov = 1;
            end else begin
                sh = s32 >> 1;
                m  = sh[22:0];
                eo = 8'(int'(e) + 1);
            end
        end else if (s >= 25'h0800000) begin
            m = s[22:0];
        end else begin
            p = 0;
            for (int b = 0; b < 25; b++) if (s[b]) p = b;
            n = 23 - p;
            if (int'(e) > n) begin
                sh  = s32 << n;
                m   = sh[22:0];
                eo  = 8'(int'(e) - n);
                lat = 2 + n;
            end else begin
                k   = (int'(e) > 1) ? int'(e) - 1 : 0;
                sh  = s32 << k;
                m   = sh[22:0];
                eo  = 8'h00;
                uf  = 1;
                lat = 3 + k;
            end
        end
        res = {m, eo, sg, ov, uf, zr};
    endtask

    // Present one operand, wait (bounded) for the result, sample it, then
    // complete the output handshake. lat = -1 on timeout.
    task automatic do_op(input logic [24:0] s, input logic [7:0] e, input logic sg,
                         output logic [34:0] res, output int lat);
        int w;
        @(negedge clk);
        bus_if.sum_ment_in = s;
        bus_if.expo_in     = e;
        bus_if.sign_in     = sg;
        bus_if.in_valid    = 1'b1;
        w = 0;
        while (!bus_if.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus_if.out_valid) lat = -1;
        res = dut_res();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.out_valid, bus_if.in_ready, dut_res()} !== {2'b01, 35'd0}) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b res=%h want 0/1/0",
                     bus_if.out_valid, bus_if.in_ready, dut_res());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [24:0] s;
        logic [7:0]  e;
        logic        sg;
        logic [22:0] m;
        logic [7:0]  eo;
        logic        ov, uf, zr;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v[10];
        logic [34:0] got;
        logic [34:0] want;
        int          lat;
        v[0] = '{25'h0800000, 8'h80, 1'b1, 23'h000000, 8'h80, 0, 0, 0, 2};
        v[1] = '{25'h1800000, 8'h80, 1'b0, 23'h400000, 8'h81, 0, 0, 0, 2};
        v[2] = '{25'h1800000, 8'hFE, 1'b0, 23'h000000, 8'hFF, 1, 0, 0, 2};
        v[3] = '{25'h0000001, 8'h80, 1'b0, 23'h000000, 8'h69, 0, 0, 0, 25};
        v[4] = '{25'h0000000, 8'h80, 1'b1, 23'h000000, 8'h00, 0, 0, 1, 2};
        v[5] = '{25'h0200000, 8'h02, 1'b1, 23'h400000, 8'h00, 0, 1, 0, 4};
        v[6] = '{25'h1000000, 8'hFF, 1'b0, 23'h000000, 8'hFF, 1, 0, 0, 2};
        v[7] = '{25'h0A00000, 8'hFF, 1'b1, 23'h200000, 8'hFF, 0, 0, 0, 2};
        v[8] = '{25'h0000001, 8'h17, 1'b0, 23'h400000, 8'h00, 0, 1, 0, 25};
        v[9] = '{25'h0000001, 8'h18, 1'b1, 23'h000000, 8'h01, 0, 0, 0, 25};
        for (int i = 0; i < 10; i++) begin
            do_op(v[i].s, v[i].e, v[i].sg, got, lat);
            want = {v[i].m, v[i].eo, v[i].sg, v[i].ov, v[i].uf, v[i].zr};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL directed[%0d] result: got %h want %h", i, got, want);
            end
            checks++;
            if (lat != v[i].lat) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [24:0] s;
        logic [7:0]  e;
        logic        sg;
        logic [34:0] got, want;
        int          lat, wlat, cls, p;
        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 9);
            sg  = 1'($urandom);
            e   = 8'($urandom_range(0, 254));
            if (cls == 0) begin
                s = '0;
            end else if (cls <= 3) begin
                s = {1'b1, 24'($urandom)};
                if (cls == 3) e = 8'($urandom_range(252, 254));
            end else if (cls <= 5) begin
                s = {2'b01, 23'($urandom)};
            end else begin
                p = $urandom_range(0, 22);
                s = 25'(1) << p;
                s = s | (25'($urandom) & ((25'(1) << p) - 25'(1)));
                if (cls >= 8) e = 8'($urandom_range(0, 24));
            end
            ref_model(s, e, sg, want, wlat);
            do_op(s, e, sg, got, lat);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random[%0d] s=%h e=%h result: got %h want %h", i, s, e, got, want);
            end
            checks++;
            if (lat != wlat) begin
                errors++;
                $display("FAIL random[%0d] s=%h e=%h latency: got %0d want %0d", i, s, e, lat, wlat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [34:0] want1, want2;
        int          wlat1, wlat2, lat;
        ref_model(25'h0C00000, 8'h40, 1'b1, want1, wlat1);
        ref_model(25'h0400000, 8'h50, 1'b0, want2, wlat2);
        @(negedge clk);
        bus_if.sum_ment_in = 25'h0C00000;
        bus_if.expo_in     = 8'h40;
        bus_if.sign_in     = 1'b1;
        bus_if.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (dut_res() !== want1 || lat != wlat1) begin
            errors++;
            $display("FAIL bp_first: got %h lat %0d want %h lat %0d", dut_res(), lat, want1, wlat1);
        end
        // Offer a second operand while the first result is stalled.
        bus_if.sum_ment_in = 25'h0400000;
        bus_if.expo_in     = 8'h50;
        bus_if.sign_in     = 1'b0;
        bus_if.in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus_if.out_valid, bus_if.in_ready, dut_res()} !== {2'b10, want1}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h want 1/0/%h",
                         i, bus_if.out_valid, bus_if.in_ready, dut_res(), want1);
            end
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        checks++;
        if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0/1", bus_if.out_valid, bus_if.in_ready);
        end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (dut_res() !== want2 || lat != wlat2) begin
            errors++;
            $display("FAIL bp_second: got %h lat %0d want %h lat %0d", dut_res(), lat, want2, wlat2);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [34:0] want_a, want_b;
        int          la, lb;
        ref_model(25'h0900000, 8'h10, 1'b0, want_a, la);
        ref_model(25'h1A00000, 8'h20, 1'b1, want_b, lb);
        @(negedge clk);
        bus_if.out_ready   = 1'b1;
        bus_if.sum_ment_in = 25'h0900000;
        bus_if.expo_in     = 8'h10;
        bus_if.sign_in     = 1'b0;
        bus_if.in_valid    = 1'b1;
        @(posedge clk); #1;                 // A accepted
        bus_if.sum_ment_in = 25'h1A00000;
        bus_if.expo_in     = 8'h20;
        bus_if.sign_in     = 1'b1;
        checks++;
        if (bus_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: in_ready=%b want 0", bus_if.in_ready);
        end
        @(posedge clk); #1;                 // A result presented
        checks++;
        if ({bus_if.out_valid, dut_res()} !== {1'b1, want_a}) begin
            errors++;
            $display("FAIL b2b_a: vld=%b res=%h want 1/%h", bus_if.out_valid, dut_res(), want_a);
        end
        @(posedge clk); #1;                 // mandatory idle cycle
        checks++;
        if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_idle: vld=%b rdy=%b want 0/1", bus_if.out_valid, bus_if.in_ready);
        end
        @(posedge clk); #1;                 // B accepted
        bus_if.in_valid = 1'b0;
        checks++;
        if ({bus_if.out_valid, bus_if.in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_accept: vld=%b rdy=%b want 0/0", bus_if.out_valid, bus_if.in_ready);
        end
        @(posedge clk); #1;                 // B result presented
        checks++;
        if ({bus_if.out_valid, dut_res()} !== {1'b1, want_b}) begin
            errors++;
            $display("FAIL b2b_b: vld=%b res=%h want 1/%h", bus_if.out_valid, dut_res(), want_b);
        end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [34:0] got, want;
        int          lat, wlat;
        bit          seen;
        @(negedge clk);
        bus_if.sum_ment_in = 25'h0000001;
        bus_if.expo_in     = 8'h80;
        bus_if.sign_in     = 1'b1;
        bus_if.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus_if.out_valid, bus_if.in_ready, dut_res()} !== {2'b01, 35'd0}) begin
            errors++;
            $display("FAIL reset_mid: vld=%b rdy=%b res=%h want 0/1/0",
                     bus_if.out_valid, bus_if.in_ready, dut_res());
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) seen = 1;
        end
        bus_if.out_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_stale: out_valid seen=1 want 0");
        end
        ref_model(25'h1400000, 8'h33, 1'b0, want, wlat);
        do_op(25'h1400000, 8'h33, 1'b0, got, lat);
        checks++;
        if (got !== want || lat != wlat) begin
            errors++;
            $display("FAIL reset_mid_after: got %h lat %0d want %h lat %0d", got, lat, want, wlat);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n              = 1'b0;
        bus_if.in_valid    = 1'b0;
        bus_if.out_ready   = 1'b0;
        bus_if.sum_ment_in = '0;
        bus_if.expo_in     = '0;
        bus_if.sign_in     = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
